// File: rtl/decode_stage.sv
// decode_stage: RV32 decode into a 2-entry skid buffer; DECODE_SYSTEM_EN makes fence/system legal.
module decode_stage #(
  parameter int PC_W = 32,
  parameter int ILEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [ILEN-1:0] i_instr,
  input  logic [PC_W-1:0] i_pc,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [ILEN-1:0] o_instr,
  output logic [PC_W-1:0] o_pc,
  output logic [15:0]     o_ctrl,
  output logic            o_illegal
);
  localparam int W = ILEN + PC_W + 17;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state_q, state_d;
  logic [W-1:0] ent_q [2];
  logic [W-1:0] ent_d [2];
  logic [W-1:0] ent_in;
  logic [6:0] op;
  logic [2:0] f3;
  logic [13:0] c14;
  logic [1:0] lo;
  logic ill, push, pop;
  assign op = i_instr[6:0];
  assign f3 = i_instr[14:12];
  always_comb begin
    c14 = '0;
    lo = {f3[2], ~op[5]};
    ill = 1'b0;
    case (op)
      7'b0000011: c14 = 14'b00_1_000_01_1_1_0_0_0_0;
      7'b0010011: c14 = f3[1:0] == 2'b01 ? 14'b10_1_010_00_1_0_0_0_0_0 : 14'b10_1_001_00_1_0_0_0_0_0;
      7'b0100011: c14 = 14'b00_1_011_00_0_1_1_0_0_0;
      7'b0110011: c14 = 14'b10_0_000_00_1_0_0_0_0_0;
      7'b0010111, 7'b0110111: c14 = 14'b00_0_100_10_1_0_0_0_0_0;
      7'b1100011: c14 = 14'b01_0_101_00_0_0_0_1_0_0;
      7'b1100111: c14 = 14'b00_0_110_11_1_0_0_0_0_1;
      7'b1101111: c14 = 14'b00_0_111_11_1_0_0_0_1_0;
      7'b0000000: lo = 2'b00;
`ifdef DECODE_SYSTEM_EN
      7'b0001111: lo = 2'b00;
      7'b1110011: lo = 2'b10;
`endif
      default: ill = 1'b1;
    endcase
  end
  assign ent_in = {i_instr, i_pc, c14, lo, ill};
  assign o_ready = state_q != FULL && i_rst_n;
  assign o_valid = state_q != EMPTY && i_rst_n;
  assign {o_instr, o_pc, o_ctrl, o_illegal} = o_valid ? ent_q[0] : '0;
  assign push = i_valid && o_ready;
  assign pop = o_valid && i_ready;
  // push+pop can only happen in ONE, since FULL blocks push and EMPTY blocks pop
  always_comb begin
    state_d = state_q;
    ent_d = ent_q;
    if (i_flush) state_d = EMPTY;
    else if (push && !pop) begin
      ent_d[state_q != EMPTY] = ent_in;
      state_d = state_q == EMPTY ? ONE : FULL;
    end else if (pop && !push) begin
      ent_d[0] = ent_q[1];
      state_d = state_q == FULL ? ONE : EMPTY;
    end else if (push && pop) ent_d[0] = ent_in;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      ent_q[0] <= '0;
      ent_q[1] <= '0;
    end else begin
      state_q <= state_d;
      ent_q <= ent_d;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage (decode table, backpressure, flush, reset).
module tb_decode_stage;
  logic clk = 0, rst_n = 0, i_valid = 0, i_flush = 0, i_ready = 0;
  logic [31:0] i_instr = 0, i_pc = 0;
  logic o_ready, o_valid, o_illegal;
  logic [31:0] o_instr, o_pc;
  logic [15:0] o_ctrl;
  logic [15:0] exp_ctrl = 0, exp_mask = 16'hFFFF;
  logic exp_ill = 0;
  int total = 0, bad = 0;
  typedef struct {logic [31:0] instr; logic [31:0] pc; logic [15:0] ctrl; logic [15:0] mask; logic ill;} exp_t;
  exp_t q[$];
  exp_t e;
  logic hold = 0;
  logic [80:0] saved;

  decode_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_instr(o_instr), .o_pc(o_pc), .o_ctrl(o_ctrl), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!o_valid) begin
      total++;
      if ({o_ctrl, o_illegal, o_instr, o_pc} !== 81'd0) begin
        bad++;
        $display("FAIL idle_zero: got ctrl=%h ill=%b instr=%h pc=%h want all 0", o_ctrl, o_illegal, o_instr, o_pc);
      end
    end
    if (hold) begin
      total++;
      if ({o_valid, o_ctrl, o_illegal, o_instr, o_pc} !== {1'b1, saved}) begin
        bad++;
        $display("FAIL hold_stable: got %h want %h", {o_ctrl, o_illegal, o_instr, o_pc}, saved);
      end
    end
    if (!rst_n || i_flush) q.delete();
    else begin
      if (o_valid && i_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_out: got instr=%h pc=%h want no output", o_instr, o_pc);
        end else begin
          e = q.pop_front();
          if (o_instr !== e.instr || o_pc !== e.pc || (o_ctrl & e.mask) !== e.ctrl || o_illegal !== e.ill) begin
            bad++;
            $display("FAIL sb_out: got instr=%h pc=%h ctrl=%h ill=%b want instr=%h pc=%h ctrl=%h(mask %h) ill=%b",
                     o_instr, o_pc, o_ctrl, o_illegal, e.instr, e.pc, e.ctrl, e.mask, e.ill);
          end
        end
      end
      if (i_valid && o_ready) q.push_back('{i_instr, i_pc, exp_ctrl, exp_mask, exp_ill});
    end
    hold = o_valid && !i_ready && !i_flush && rst_n;
    saved = {o_ctrl, o_illegal, o_instr, o_pc};
  end

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc, input logic [15:0] c, input logic [15:0] m, input logic il);
    i_valid = 1; i_instr = ins; i_pc = pc; exp_ctrl = c; exp_mask = m; exp_ill = il;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    total++;
    if (q.size() != 0 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain: got pending=%0d valid=%b want 0 and 0", name, q.size(), o_valid);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (o_valid !== 0 || o_ctrl !== 0 || o_ready !== 0) begin
        bad++;
        $display("FAIL reset_hold: got valid=%b ctrl=%h ready=%b want 0 0 0", o_valid, o_ctrl, o_ready);
      end
    end
    next_cycle();
    rst_n = 1;
    @(negedge clk);
    total++;
    if (o_ready !== 1 || o_valid !== 0) begin
      bad++;
      $display("FAIL reset_release: got ready=%b valid=%b want 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_basic;
    next_cycle();
    i_ready = 1;
    drive(32'h00A00093, 32'h100, {14'b10_1_001_00_1_0_0_0_0_0, 2'b01}, 16'hFFFF, 0);
    next_cycle();
    i_valid = 0;
    @(negedge clk);
    total++;
    if (o_valid !== 1 || o_ctrl !== {14'b10_1_001_00_1_0_0_0_0_0, 2'b01} || o_illegal !== 0) begin
      bad++;
      $display("FAIL basic_latency: got valid=%b ctrl=%h ill=%b want 1 %h 0", o_valid, o_ctrl, o_illegal,
               {14'b10_1_001_00_1_0_0_0_0_0, 2'b01});
    end
    wait_drain("basic");
  endtask

  task automatic test_decode;
    logic [31:0] ins [17];
    logic [15:0] ctl [17];
    logic [15:0] msk [17];
    logic ilg [17];
    ins = '{32'h00012083, 32'h00014083, 32'h00109093, 32'h0010D093, 32'h0FF0F093, 32'h0020A023,
            32'h002081B3, 32'h00001097, 32'h000010B7, 32'h00208063, 32'h000080E7, 32'h008000EF,
            32'h00000000, 32'hFFFFFFFF, 32'h00012081, 32'h00000073, 32'h0000000F};
    ctl = '{{14'b00_1_000_01_1_1_0_0_0_0, 2'b01}, {14'b00_1_000_01_1_1_0_0_0_0, 2'b11},
            {14'b10_1_010_00_1_0_0_0_0_0, 2'b01}, {14'b10_1_010_00_1_0_0_0_0_0, 2'b11},
            {14'b10_1_001_00_1_0_0_0_0_0, 2'b11}, {14'b00_1_011_00_0_1_1_0_0_0, 2'b00},
            {14'b10_0_000_00_1_0_0_0_0_0, 2'b00}, {14'b00_0_100_10_1_0_0_0_0_0, 2'b01},
            {14'b00_0_100_10_1_0_0_0_0_0, 2'b00}, {14'b01_0_101_00_0_0_0_1_0_0, 2'b00},
            {14'b00_0_110_11_1_0_0_0_0_1, 2'b00}, {14'b00_0_111_11_1_0_0_0_1_0, 2'b00},
            16'h0, 16'h0, 16'h0,
`ifdef DECODE_SYSTEM_EN
            16'h0002, 16'h0};
    msk = '{default: 16'hFFFF};
    msk[13] = 16'hFFFC; msk[14] = 16'hFFFC;
    ilg = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
`else
            16'h0, 16'h0};
    msk = '{default: 16'hFFFF};
    for (int i = 13; i < 17; i++) msk[i] = 16'hFFFC;
    ilg = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
`endif
    i_ready = 1;
    for (int i = 0; i < 17; i++) begin
      drive(ins[i], 32'h1000 + 32'(i * 4), ctl[i], msk[i], ilg[i]);
      next_cycle();
    end
    i_valid = 0;
    wait_drain("decode");
  endtask

  task automatic test_back_to_back;
    i_ready = 0;
    drive(32'h00100093, 32'h2000, {14'b10_1_001_00_1_0_0_0_0_0, 2'b01}, 16'hFFFF, 0);
    next_cycle();
    drive(32'h002081B3, 32'h2004, {14'b10_0_000_00_1_0_0_0_0_0, 2'b00}, 16'hFFFF, 0);
    next_cycle();
    drive(32'h0020A023, 32'h2008, {14'b00_1_011_00_0_1_1_0_0_0, 2'b00}, 16'hFFFF, 0);
    repeat (2) begin
      @(negedge clk);
      total++;
      if (o_ready !== 0 || o_instr !== 32'h00100093 || o_pc !== 32'h2000) begin
        bad++;
        $display("FAIL b2b_full: got ready=%b instr=%h pc=%h want 0 00100093 00002000", o_ready, o_instr, o_pc);
      end
      next_cycle();
    end
    i_valid = 0;
    i_ready = 1;
    wait_drain("b2b");
  endtask

  task automatic test_flush;
    i_ready = 0;
    drive(32'h00000013, 32'h3000, {14'b10_1_001_00_1_0_0_0_0_0, 2'b01}, 16'hFFFF, 0);
    next_cycle();
    drive(32'h00000033, 32'h3004, {14'b10_0_000_00_1_0_0_0_0_0, 2'b00}, 16'hFFFF, 0);
    next_cycle();
    drive(32'h00300093, 32'h3008, {14'b10_1_001_00_1_0_0_0_0_0, 2'b01}, 16'hFFFF, 0);
    i_flush = 1;
    next_cycle();
    i_flush = 0;
    i_valid = 0;
    @(negedge clk);
    total++;
    if (o_valid !== 0 || o_ready !== 1) begin
      bad++;
      $display("FAIL flush_empty: got valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
    i_ready = 1;
    repeat (3) @(negedge clk);
    wait_drain("flush");
  endtask

  task automatic test_reset_mid;
    next_cycle();
    i_ready = 0;
    drive(32'h00400093, 32'h4000, {14'b10_1_001_00_1_0_0_0_0_0, 2'b01}, 16'hFFFF, 0);
    next_cycle();
    drive(32'h00500093, 32'h4004, {14'b10_1_001_00_1_0_0_0_0_0, 2'b01}, 16'hFFFF, 0);
    i_ready = 1;
    rst_n = 0;
    @(negedge clk);
    total++;
    if (o_ready !== 0 || o_valid !== 0) begin
      bad++;
      $display("FAIL reset_mid: got ready=%b valid=%b want 0 0", o_ready, o_valid);
    end
    next_cycle();
    rst_n = 1;
    i_valid = 0;
    @(negedge clk);
    total++;
    if (o_valid !== 0 || o_ready !== 1) begin
      bad++;
      $display("FAIL reset_mid_after: got valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
    wait_drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
